// File: rtl/div_hilo_ctrl.sv
// HI/LO sequencer between EX and the shared signed divider: takes DIV/MTHI/MTLO/MFHI/MFLO,
// launches the divider, commits quotient/remainder and stalls EX while a result is pending.
module div_hilo_ctrl #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 7
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        op_valid,
  input  logic [2:0]  op,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic        flush,
  output logic        stall,
  output logic [31:0] rd_data,
  output logic        rd_valid,
  output logic [31:0] div_a,
  output logic [31:0] div_b,
  output logic        div_start,
  input  logic        div_busy,
  input  logic [31:0] div_q,
  input  logic [31:0] div_r,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        dz,
  output logic        timeout_err
);

  // state   | meaning
  // IDLE    | accepting ops; MFHI/MFLO answered combinationally
  // START   | div_start asserted for this single cycle
  // WAIT_HI | waiting for the divider to raise div_busy
  // WAIT_LO | waiting for div_busy to fall, then commit HI/LO
  // DRAIN   | flushed divide still running; wait it out, no commit
  typedef enum logic [2:0] {IDLE, START, WAIT_HI, WAIT_LO, DRAIN} state_t;

  localparam logic [2:0] OP_DIV  = 3'd1;
  localparam logic [2:0] OP_MTHI = 3'd2;
  localparam logic [2:0] OP_MTLO = 3'd3;
  localparam logic [2:0] OP_MFHI = 3'd4;
  localparam logic [2:0] OP_MFLO = 3'd5;

  state_t           state;
  logic [CNT_W-1:0] wd_cnt;
  logic             op_known;
  logic             accept;
  logic             div_ovf;
  logic             wd_last;

  assign op_known  = (op != 3'd0) && (op <= OP_MFLO);
  assign accept    = op_valid && !flush && (state == IDLE);
  assign div_ovf   = (rs_data == 32'h8000_0000) && (rt_data == 32'hFFFF_FFFF);
  assign wd_last   = (wd_cnt >= CNT_W'(TIMEOUT - 1));
  assign stall     = op_valid && op_known && (state != IDLE);
  assign div_start = (state == START) && !flush;

  always_comb begin
    rd_valid = 1'b0;
    rd_data  = 32'd0;
    if (accept && op == OP_MFHI) begin
      rd_valid = 1'b1;
      rd_data  = hi;
    end else if (accept && op == OP_MFLO) begin
      rd_valid = 1'b1;
      rd_data  = lo;
    end
  end

  always_ff @(posedge clock) begin
    if (resetn) begin
      state       <= IDLE;
      hi          <= 32'd0;
      lo          <= 32'd0;
      div_a       <= 32'd0;
      div_b       <= 32'd0;
      wd_cnt      <= '0;
      dz          <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      dz <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            case (op)
              OP_MTHI: hi <= rs_data;
              OP_MTLO: lo <= rs_data;
              OP_DIV: begin
                if (rt_data == 32'd0) begin
                  dz <= 1'b1;
                end else if (div_ovf) begin
                  lo <= 32'h8000_0000;
                  hi <= 32'd0;
                end else begin
                  div_a <= rs_data;
                  div_b <= rt_data;
                  state <= START;
                end
              end
              default: ;
            endcase
          end
        end
        START: begin
          wd_cnt <= '0;
          state  <= flush ? IDLE : WAIT_HI;
        end
        // Seeing busy rise takes priority over the watchdog so a timeout from
        // WAIT_HI always means the divider never started.
        WAIT_HI: begin
          wd_cnt <= wd_cnt + 1'b1;
          if (flush) begin
            state <= IDLE;
          end else if (div_busy) begin
            state <= WAIT_LO;
          end else if (wd_last) begin
            timeout_err <= 1'b1;
            state       <= IDLE;
          end
        end
        WAIT_LO: begin
          wd_cnt <= wd_cnt + 1'b1;
          if (flush) begin
            state <= DRAIN;
          end else if (!div_busy) begin
            hi    <= div_r;
            lo    <= div_q;
            state <= IDLE;
          end else if (wd_last) begin
            timeout_err <= 1'b1;
            state       <= IDLE;
          end
        end
        DRAIN: begin
          if (!div_busy) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_hilo_ctrl.sv
// Directed bench for div_hilo_ctrl with a simple 32-cycle divider model
// (optionally hung busy for the watchdog case).
module tb_div_hilo_ctrl;

  logic        clock = 1'b0;
  logic        resetn;
  logic        op_valid;
  logic [2:0]  op;
  logic [31:0] rs_data, rt_data;
  logic        flush;
  logic        stall, rd_valid, div_start, dz, timeout_err;
  logic [31:0] rd_data, div_a, div_b, hi, lo;
  logic        div_busy = 1'b0;
  logic [31:0] div_q = 32'd0, div_r = 32'd0;

  logic        hang = 1'b0;
  int          dcnt = 0;
  int          tests = 0;
  int          fails = 0;

  div_hilo_ctrl #(.TIMEOUT(64), .CNT_W(7)) dut (
    .clock(clock), .resetn(resetn), .op_valid(op_valid), .op(op),
    .rs_data(rs_data), .rt_data(rt_data), .flush(flush), .stall(stall),
    .rd_data(rd_data), .rd_valid(rd_valid), .div_a(div_a), .div_b(div_b),
    .div_start(div_start), .div_busy(div_busy), .div_q(div_q), .div_r(div_r),
    .hi(hi), .lo(lo), .dz(dz), .timeout_err(timeout_err)
  );

  always #5 clock = ~clock;

  // Divider model: busy rises the edge after div_start, falls 32 cycles later.
  always @(posedge clock) begin
    if (resetn) begin
      div_busy <= 1'b0;
      dcnt     <= 0;
    end else if (div_start && !div_busy) begin
      div_busy <= 1'b1;
      dcnt     <= 32;
      div_q    <= $signed(div_a) / $signed(div_b);
      div_r    <= $signed(div_a) % $signed(div_b);
    end else if (div_busy && !hang) begin
      dcnt <= dcnt - 1;
      if (dcnt == 1) div_busy <= 1'b0;
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    op_valid = v;
    op       = o;
    rs_data  = a;
    rt_data  = b;
  endtask

  // Issue DIV (waiting out any stall), hold MFLO behind it, check the commit.
  task automatic div_run(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_q, input logic [31:0] exp_r,
                         input logic [31:0] prev_hi, input logic [31:0] prev_lo);
    bit done;
    int starts;
    drive(1'b1, 3'd1, a, b);
    #1;
    done = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (!stall) begin done = 1'b1; break; end
      @(negedge clock); #1;
    end
    check({tag, "_accept"}, {31'd0, done}, 32'd1);
    check({tag, "_prev_hi"}, hi, prev_hi);
    check({tag, "_prev_lo"}, lo, prev_lo);
    @(negedge clock);
    drive(1'b1, 3'd5, 32'd0, 32'd0);
    #1;
    check({tag, "_start"}, {31'd0, div_start}, 32'd1);
    check({tag, "_stall"}, {31'd0, stall}, 32'd1);
    starts = 1;
    done   = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock); #1;
      if (div_start) starts++;
      if (!stall) begin done = 1'b1; break; end
    end
    check({tag, "_done"}, {31'd0, done}, 32'd1);
    check({tag, "_starts"}, 32'(starts), 32'd1);
    check({tag, "_rd_valid"}, {31'd0, rd_valid}, 32'd1);
    check({tag, "_rd_data"}, rd_data, exp_q);
    check({tag, "_lo"}, lo, exp_q);
    check({tag, "_hi"}, hi, exp_r);
    @(negedge clock);
    drive(1'b0, 3'd0, 32'd0, 32'd0);
  endtask

  initial begin
    bit ok;
    int cyc;
    resetn = 1'b1;
    flush  = 1'b0;
    drive(1'b0, 3'd0, 32'd0, 32'd0);
    repeat (2) @(negedge clock);
    resetn = 1'b0;
    #1;
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    check("rst_timeout", {31'd0, timeout_err}, 32'd0);
    check("rst_div_start", {31'd0, div_start}, 32'd0);

    drive(1'b1, 3'd4, 32'd0, 32'd0); #1;
    check("mfhi_rst_valid", {31'd0, rd_valid}, 32'd1);
    check("mfhi_rst_data", rd_data, 32'd0);
    check("mfhi_rst_stall", {31'd0, stall}, 32'd0);
    drive(1'b1, 3'd5, 32'd0, 32'd0); #1;
    check("mflo_rst_valid", {31'd0, rd_valid}, 32'd1);
    check("mflo_rst_data", rd_data, 32'd0);

    @(negedge clock); drive(1'b1, 3'd2, 32'h1234_5678, 32'd0);
    @(negedge clock); drive(1'b1, 3'd4, 32'd0, 32'd0); #1;
    check("mthi_mfhi", rd_data, 32'h1234_5678);
    @(negedge clock); drive(1'b1, 3'd3, 32'hDEAD_BEEF, 32'd0);
    @(negedge clock); drive(1'b1, 3'd5, 32'd0, 32'd0); #1;
    check("mtlo_mflo", rd_data, 32'hDEAD_BEEF);
    @(negedge clock); drive(1'b0, 3'd0, 32'd0, 32'd0);

    div_run("div_pos", 32'd100, 32'd7, 32'd14, 32'd2, 32'h1234_5678, 32'hDEAD_BEEF);
    div_run("div_neg", 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 32'd2, 32'd14);

    @(negedge clock); drive(1'b1, 3'd2, 32'd5, 32'd0);
    @(negedge clock); drive(1'b1, 3'd3, 32'd9, 32'd0);
    @(negedge clock); drive(1'b1, 3'd1, 32'd77, 32'd0); #1;
    check("dz_accept_stall", {31'd0, stall}, 32'd0);
    @(negedge clock); drive(1'b0, 3'd0, 32'd0, 32'd0); #1;
    check("dz_pulse", {31'd0, dz}, 32'd1);
    check("dz_no_start", {31'd0, div_start}, 32'd0);
    @(negedge clock); #1;
    check("dz_clear", {31'd0, dz}, 32'd0);
    check("dz_hi", hi, 32'd5);
    check("dz_lo", lo, 32'd9);

    drive(1'b1, 3'd1, 32'h8000_0000, 32'hFFFF_FFFF);
    @(negedge clock); drive(1'b0, 3'd0, 32'd0, 32'd0); #1;
    check("ovf_no_start", {31'd0, div_start}, 32'd0);
    check("ovf_lo", lo, 32'h8000_0000);
    check("ovf_hi", hi, 32'd0);
    check("ovf_dz", {31'd0, dz}, 32'd0);

    // Flush a 1000/3 in WAIT_LO, then queue a DIV behind the drain.
    @(negedge clock); drive(1'b1, 3'd1, 32'd1000, 32'd3);
    @(negedge clock); drive(1'b0, 3'd0, 32'd0, 32'd0);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (div_busy) begin ok = 1'b1; break; end
    end
    check("flush_busy_seen", {31'd0, ok}, 32'd1);
    repeat (5) @(negedge clock);
    flush = 1'b1;
    @(negedge clock);
    flush = 1'b0;
    drive(1'b1, 3'd1, 32'd50, 32'd6); #1;
    check("drain_stall", {31'd0, stall}, 32'd1);
    check("drain_no_start", {31'd0, div_start}, 32'd0);
    div_run("div_after_drain", 32'd50, 32'd6, 32'd8, 32'd2, 32'd0, 32'h8000_0000);

    // Hung divider: watchdog must release after START + 64 wait cycles.
    hang = 1'b1;
    @(negedge clock); drive(1'b1, 3'd1, 32'd9, 32'd4);
    @(negedge clock); drive(1'b1, 3'd4, 32'd0, 32'd0); #1;
    cyc = 0;
    ok  = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (!stall) begin ok = 1'b1; break; end
      cyc++;
      @(negedge clock); #1;
    end
    check("wd_released", {31'd0, ok}, 32'd1);
    check("wd_stall_cycles", 32'(cyc), 32'd65);
    check("wd_err", {31'd0, timeout_err}, 32'd1);
    check("wd_mfhi", rd_data, 32'd2);
    check("wd_lo", lo, 32'd8);
    @(negedge clock); drive(1'b0, 3'd0, 32'd0, 32'd0); #1;
    check("wd_sticky", {31'd0, timeout_err}, 32'd1);
    hang   = 1'b0;
    resetn = 1'b1;
    @(negedge clock);
    resetn = 1'b0; #1;
    check("wd_reset_clears", {31'd0, timeout_err}, 32'd0);
    check("wd_reset_hi", hi, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/div_hilo_ctrl.md
Name: div_hilo_ctrl

Overview:
- Sequencer between the pipeline's EX stage and the shared 32-cycle signed divider.
- Accepts DIV/MTHI/MTLO/MFHI/MFLO, launches the divider, waits for completion and commits quotient to LO and remainder to HI.
- Stalls the pipeline while HI/LO are pending and handles flush, special-case operands and a completion watchdog.

Parameters:
- TIMEOUT, 64: maximum cycles spent in WAIT_HI+WAIT_LO before abandoning the operation.
- CNT_W, 7: width of the watchdog counter; must hold TIMEOUT.

Ports:
- clock  in  1  system clock, rising edge
- resetn  in  1  synchronous, active-high reset
- op_valid  in  1  operation present from EX
- op  in  3  000 none, 001 DIV, 010 MTHI, 011 MTLO, 100 MFHI, 101 MFLO; others treated as none
- rs_data  in  32  dividend / MTHI-MTLO source
- rt_data  in  32  divisor
- flush  in  1  cancel current op and any in-flight divide
- stall  out  1  pipeline must hold EX this cycle
- rd_data  out  32  MFHI/MFLO result
- rd_valid  out  1  rd_data valid this cycle
- div_a  out  32  divider dividend (registered)
- div_b  out  32  divider divisor (registered)
- div_start  out  1  one-cycle divider launch
- div_busy  in  1  divider busy
- div_q  in  32  divider quotient
- div_r  in  32  divider remainder
- hi  out  32  HI register
- lo  out  32  LO register
- dz  out  1  one-cycle pulse: DIV by zero accepted
- timeout_err  out  1  sticky watchdog error

Behaviour:
- Reset (resetn=1 at an edge):
  - State goes to IDLE.
  - hi, lo, div_a, div_b, and the watchdog counter go to 0.
  - div_start, dz, timeout_err go to 0.
  - Reset overrides every other input. An in-flight divide is abandoned; the divider shares the same reset.
- States: IDLE, START, WAIT_HI, WAIT_LO, DRAIN.
- Acceptance: an op is accepted when op_valid=1, flush=0, state=IDLE.
- stall = op_valid & (op is a valid non-none code) & (state != IDLE). stall is 0 in the accepting cycle.
- MFHI/MFLO in IDLE:
  - rd_valid=1 and rd_data=hi/lo combinationally, same cycle.
  - Otherwise rd_valid=0 and rd_data=0.
- MTHI/MTLO in IDLE: hi/lo <= rs_data at the edge. Visible to an MFHI/MFLO in the next cycle.
- DIV in IDLE, special cases (no divider launch, stay IDLE, commit at the edge):
  - rt_data=0: hi, lo unchanged; dz=1 for the following cycle.
  - rs_data=0x80000000 and rt_data=0xFFFFFFFF: lo<=0x80000000, hi<=0.
- DIV in IDLE, otherwise: div_a<=rs_data, div_b<=rt_data, state->START.
- START: div_start=1 for exactly this cycle; state->WAIT_HI; watchdog counter cleared.
- WAIT_HI: wait for div_busy=1, then ->WAIT_LO. div_busy is never sampled in the START cycle.
- WAIT_LO: on div_busy=0, hi<=div_r, lo<=div_q, state->IDLE. The next op may be accepted in the following cycle.
- Watchdog:
  - Counter increments each cycle in WAIT_HI/WAIT_LO.
  - On reaching TIMEOUT: timeout_err<=1 (sticky until reset), state->IDLE, hi/lo unchanged.
  - A timeout taken from WAIT_HI cannot leave the divider busy.
- Flush:
  - In IDLE: the same-cycle op is ignored; no state change.
  - In START: div_start is suppressed; state->IDLE.
  - In WAIT_HI: ->IDLE.
  - In WAIT_LO: ->DRAIN. DRAIN waits for div_busy=0, then ->IDLE with no HI/LO write.
  - Flush and completion in the same WAIT_LO cycle: flush wins; no commit.
- div_a/div_b hold their value until the next accepted DIV.

Test Plan:
- Reset, then MFHI and MFLO -> rd_valid=1, rd_data=0 both; stall=0.
- MTHI 0x12345678, next cycle MFHI -> rd_data=0x12345678; MTLO 0xDEADBEEF then MFLO -> 0xDEADBEEF.
- DIV rs=100 (0x64), rt=7, MFLO held valid behind it:
  - div_start pulses exactly one cycle after acceptance.
  - stall stays high until commit; lo=14, hi=2.
  - Repeat with rs=-100, rt=7 -> lo=0xFFFFFFF2 (-14), hi=0xFFFFFFFE (-2).
- DIV rt=0 with hi=5, lo=9 -> no div_start, dz pulses one cycle, hi=5, lo=9. DIV 0x80000000 by -1 -> lo=0x80000000, hi=0, no div_start.
- DIV 1000/3, flush asserted 5 cycles after div_busy rises:
  - State goes to DRAIN; no HI/LO update when div_busy drops.
  - A DIV issued during DRAIN stalls, then completes correctly with a fresh div_start.
- Divider model holding div_busy=1 forever -> after 64 cycles timeout_err=1, stall released, hi/lo unchanged; resetn=1 for one cycle clears timeout_err.
